// File: rtl/pw_det_pkg.sv
// pw_det_pkg -- shared constants and helpers for the PW_Detection path.
// Rev 1.0
`default_nettype none

package pw_det_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DN    = 1'b1;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

  // Effective modulus, one bit wider than the counter so 2^WIDTH is representable.
  function automatic logic [32:0] eff_mod(input logic [31:0] mod_val, input int width);
    if (mod_val == '0) return 33'(1) << width;
    return {1'b0, mod_val};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pw_edge_sync.sv
// pw_edge_sync -- optional synchroniser chain followed by a rising-edge detector.
// Rev 1.0
`default_nettype none

module pw_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkout,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic synced;
  logic prev;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge clkout or posedge reset) begin
        if (reset) begin
          chain <= '0;
        end else begin
          chain[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
        end
      end
      assign synced = chain[SYNC_STAGES-1];
    end else begin : g_bypass
      assign synced = din;
    end
  endgenerate

  always_ff @(posedge clkout or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= synced;
  end

  assign rise = synced & ~prev;

endmodule

`default_nettype wire

// File: rtl/ref_tick_counter.sv
// ref_tick_counter -- programmable-modulus tick counter with event timestamp capture.
// Rev 1.0
`default_nettype none

module ref_tick_counter
  import pw_det_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int SAT_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkout,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             evt_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_vld
);

  localparam logic           IS_SAT = (SAT_MODE == MODE_SAT);
  localparam logic [WIDTH:0] ONE    = (WIDTH+1)'(1);

  logic [32:0]    m_full;
  logic [WIDTH:0] m, m_last, cnt_x, ld_x, cnt_nx;
  logic           oob, tc_nx, ovf_nx, evt_rise;

  assign m_full = eff_mod(32'(mod_val), WIDTH);
  assign m      = m_full[WIDTH:0];
  assign m_last = m - ONE;
  assign cnt_x  = {1'b0, count};
  assign ld_x   = {1'b0, load_val};
  // Count left beyond a freshly shrunk modulus must be pulled back into range.
  assign oob    = (cnt_x >= m);

  generate
    if (WIDTH < 32) begin : g_mod_unused
      logic unused_mod_hi;
      assign unused_mod_hi = |m_full[32:WIDTH+1];
    end
  endgenerate

  logic unused_cnt_msb;
  assign unused_cnt_msb = cnt_nx[WIDTH];

  always_comb begin
    cnt_nx = cnt_x;
    tc_nx  = 1'b0;
    ovf_nx = ovf;
    if (clr) begin
      cnt_nx = '0;
      ovf_nx = 1'b0;
    end else if (load) begin
      cnt_nx = (ld_x >= m) ? m_last : ld_x;
    end else if (en) begin
      if (dir == DIR_DN) begin
        if (oob || (cnt_x == '0 && !IS_SAT)) begin
          cnt_nx = m_last;
          tc_nx  = 1'b1;
          ovf_nx = 1'b1;
        end else if (cnt_x == '0) begin
          ovf_nx = 1'b1;
        end else begin
          cnt_nx = cnt_x - ONE;
          if (IS_SAT && cnt_x == ONE) begin
            tc_nx  = 1'b1;
            ovf_nx = 1'b1;
          end
        end
      end else begin
        if (oob || (cnt_x == m_last && !IS_SAT)) begin
          cnt_nx = '0;
          tc_nx  = 1'b1;
          ovf_nx = 1'b1;
        end else if (cnt_x == m_last) begin
          ovf_nx = 1'b1;
        end else begin
          cnt_nx = cnt_x + ONE;
          if (IS_SAT && cnt_nx == m_last) begin
            tc_nx  = 1'b1;
            ovf_nx = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clkout or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= cnt_nx[WIDTH-1:0];
      tc    <= tc_nx;
      ovf   <= ovf_nx;
    end
  end

  pw_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_evt_sync (
    .clkout(clkout),
    .reset (reset),
    .din   (evt_in),
    .rise  (evt_rise)
  );

  // Capture samples the pre-update count, so a same-cycle clr still records it.
  always_ff @(posedge clkout or posedge reset) begin
    if (reset) begin
      cap_val <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= evt_rise;
      if (evt_rise) cap_val <= count;
    end
  end

endmodule

`default_nettype wire
